// File: rtl/photon_gate_scheduler.sv
// Sync-gated photon counter: delay/gate sequencing per sync edge, multi-frame accumulation, valid/ack result.
// Optional GATE_DBG_EN adds a registered gate_dbg pin that is high during GATE cycles.

// state | meaning
// IDLE  | waiting for a sync edge with en=1
// DELAY | counting down the latched delay
// GATE  | counting photon edges for the latched width
// DONE  | one cycle: fold frame into accumulator, maybe emit a result
module photon_gate_scheduler #(
  parameter int ACC_FRAMES     = 50,
  parameter int TIMEOUT_CYCLES = 3200000,
  parameter int CNT_W          = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_50Hz,
  input  logic             photon_pulse,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  output logic [31:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ack,
  output logic             overflow,
  output logic             sync_err,
  output logic             sync_lost
`ifdef GATE_DBG_EN
  ,
  output logic             gate_dbg
`endif
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DELAY, GATE, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sync_s, phot_s;
  logic             sync_edge, phot_edge;
  logic [CNT_W-1:0] timer, width_q;
  logic [31:0]      frame_cnt, acc, acc_new;
  logic [32:0]      acc_sum;
  logic [7:0]       frames;
  logic [TO_W-1:0]  to_cnt;
  logic             frame_last, load_result;

  // Two synchronizer flops, one history flop, then a registered edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s    <= '0;
      phot_s    <= '0;
      sync_edge <= 1'b0;
      phot_edge <= 1'b0;
    end else begin
      sync_s    <= {sync_s[1:0], sync_50Hz};
      phot_s    <= {phot_s[1:0], photon_pulse};
      sync_edge <= sync_s[1] & ~sync_s[2];
      phot_edge <= phot_s[1] & ~phot_s[2];
    end
  end

  assign acc_sum     = {1'b0, acc} + {1'b0, frame_cnt};
  assign acc_new     = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
  assign frame_last  = (frames == 8'(ACC_FRAMES - 1));
  assign load_result = en && (state == DONE) && frame_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:
          if (sync_edge) begin
            if (cfg_delay != '0)      state_nxt = DELAY;
            else if (cfg_width != '0) state_nxt = GATE;
            else                      state_nxt = DONE;
          end
        DELAY: if (timer == CNT_W'(1)) state_nxt = (width_q != '0) ? GATE : DONE;
        GATE:  if (timer == CNT_W'(1)) state_nxt = DONE;
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Timer is reused: loaded with the delay, then reloaded with the width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      width_q   <= '0;
      frame_cnt <= '0;
      acc       <= '0;
      frames    <= '0;
    end else if (!en) begin
      timer     <= '0;
      width_q   <= '0;
      frame_cnt <= '0;
      acc       <= '0;
      frames    <= '0;
    end else begin
      case (state)
        IDLE: begin
          frame_cnt <= '0;
          if (sync_edge) begin
            width_q <= cfg_width;
            timer   <= (cfg_delay != '0) ? cfg_delay : cfg_width;
          end
        end
        DELAY: timer <= (timer == CNT_W'(1)) ? width_q : timer - CNT_W'(1);
        GATE: begin
          timer <= timer - CNT_W'(1);
          if (phot_edge && frame_cnt != 32'hFFFF_FFFF) frame_cnt <= frame_cnt + 32'd1;
        end
        DONE: begin
          if (frame_last) begin
            acc    <= '0;
            frames <= '0;
          end else begin
            acc    <= acc_new;
            frames <= frames + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // An ack in the same cycle as a new result consumes the old one, so no overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (load_result) begin
      dout       <= acc_new;
      dout_valid <= 1'b1;
      if (dout_valid && !dout_ack) overflow <= 1'b1;
    end else if (dout_valid && dout_ack) begin
      dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            sync_err <= 1'b0;
    else if (sync_edge && state != IDLE)   sync_err <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      sync_lost <= 1'b0;
    end else if (!en) begin
      to_cnt    <= '0;
      sync_lost <= 1'b0;
    end else if (sync_edge) begin
      to_cnt    <= '0;
      sync_lost <= 1'b0;
    end else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) sync_lost <= 1'b1;
    end
  end

`ifdef GATE_DBG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gate_dbg <= 1'b0;
    else        gate_dbg <= (state_nxt == GATE);
  end
`endif

endmodule

// File: tb/tb_photon_gate_scheduler.sv
// Randomized bench for photon_gate_scheduler: per-frame photon windows modelled by pin-offset arithmetic.
// Builds against the default configuration and with GATE_DBG_EN defined.
`timescale 1ns/1ps
module tb_photon_gate_scheduler;
  localparam int ACC = 3;
  localparam int TMO = 2000;
  localparam int CW  = 20;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic          sync_50Hz = 1'b0, photon_pulse = 1'b0, dout_ack = 1'b0;
  logic [CW-1:0] cfg_delay = '0, cfg_width = '0;
  logic [31:0]   dout;
  logic          dout_valid, overflow, sync_err, sync_lost;
`ifdef GATE_DBG_EN
  logic          gate_dbg;
`endif

  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_acc = '0, last_res = '0;
  int          m_frames = 0;
  bit          mon_en = 1'b0;

  photon_gate_scheduler #(.ACC_FRAMES(ACC), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_50Hz(sync_50Hz), .photon_pulse(photon_pulse),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .dout(dout), .dout_valid(dout_valid),
    .dout_ack(dout_ack), .overflow(overflow), .sync_err(sync_err), .sync_lost(sync_lost)
`ifdef GATE_DBG_EN
    , .gate_dbg(gate_dbg)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Every valid cycle must match the next expected result; ack is held high while enabled.
  always @(negedge clk) begin
    if (mon_en && dout_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'(dout_valid), 32'd0);
      else                   chk("dout", dout, exp_q.pop_front());
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pin offsets k (cycles after the sync pin rises) in [d+1, d+w] land inside the gate.
  task automatic run_frame(input int d, input int w, input bit inj, input int drop_at, input bit push);
    int len, phase, cnt, ph_left, inj_at;
    bit starts[];
    len    = d + w + 12;
    phase  = int'($urandom_range(0, 3));
    cnt    = 0;
    ph_left = 0;
    inj_at = d + w / 2;
    starts = new[len];
    for (int k = 0; k < len; k++) begin
      starts[k] = (k >= 1) && (k % 4 == phase) && (k <= len - 6) && ($urandom_range(0, 1) == 1);
      if (starts[k] && k >= d + 1 && k <= d + w) cnt++;
    end
    if (drop_at >= 0) begin
      m_acc    = '0;
      m_frames = 0;
    end else begin
      if (64'(m_acc) + 64'(cnt) > 64'h0000_0000_FFFF_FFFF) m_acc = 32'hFFFF_FFFF;
      else m_acc = m_acc + 32'(cnt);
      m_frames++;
      if (m_frames == ACC) begin
        last_res = m_acc;
        if (push) exp_q.push_back(m_acc);
        m_acc    = '0;
        m_frames = 0;
      end
    end
    cfg_delay = CW'(d);
    cfg_width = CW'(w);
    for (int k = 0; k < len; k++) begin
      sync_50Hz = (k < 5) || (inj && k >= inj_at && k < inj_at + 5);
      if (ph_left > 0) begin
        photon_pulse = 1'b1;
        ph_left--;
      end else if (starts[k]) begin
        photon_pulse = 1'b1;
        ph_left = 1;
      end else begin
        photon_pulse = 1'b0;
      end
      if (drop_at >= 0) en = !(k >= drop_at && k < drop_at + 3);
      @(posedge clk);
      #1;
    end
    sync_50Hz    = 1'b0;
    photon_pulse = 1'b0;
  endtask

  initial begin
    int d, w;
    wait_cyc(3);
    rst_n = 1'b1;
    en    = 1'b1;
    wait_cyc(2);
    chk("rst_dout", dout, 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_sync_lost", 32'(sync_lost), 32'd0);

    dout_ack = 1'b1;
    mon_en   = 1'b1;
    for (int f = 0; f < 30; f++) begin
      d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 200));
      w = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 400));
      run_frame(d, w, 1'b0, -1, 1'b1);
    end
    chk("rand_overflow", 32'(overflow), 32'd0);
    chk("rand_sync_err", 32'(sync_err), 32'd0);
    chk("rand_sync_lost", 32'(sync_lost), 32'd0);

    run_frame(30, 200, 1'b1, -1, 1'b1);
    chk("inj_sync_err", 32'(sync_err), 32'd1);
    run_frame(15, 100, 1'b0, -1, 1'b1);
    run_frame(0, 150, 1'b0, -1, 1'b1);

    run_frame(20, 120, 1'b0, -1, 1'b1);
    run_frame(25, 200, 1'b0, 25 + 100, 1'b1);
    chk("drop_dout_kept", dout, last_res);
    chk("drop_valid_kept", 32'(dout_valid), 32'd0);
    for (int f = 0; f < ACC; f++) run_frame(int'($urandom_range(0, 50)), int'($urandom_range(40, 300)), 1'b0, -1, 1'b1);

    for (int f = 0; f < ACC; f++) run_frame(0, 0, 1'b0, -1, 1'b1);
    chk("zero_last_res", last_res, 32'd0);

    mon_en   = 1'b0;
    dout_ack = 1'b0;
    for (int f = 0; f < ACC; f++) run_frame(int'($urandom_range(1, 60)), int'($urandom_range(50, 200)), 1'b0, -1, 1'b0);
    chk("ovf_first_dout", dout, last_res);
    chk("ovf_first_valid", 32'(dout_valid), 32'd1);
    chk("ovf_first_flag", 32'(overflow), 32'd0);
    for (int f = 0; f < ACC; f++) run_frame(int'($urandom_range(1, 60)), int'($urandom_range(50, 200)), 1'b0, -1, 1'b0);
    chk("ovf_dout", dout, last_res);
    chk("ovf_valid", 32'(dout_valid), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    wait_cyc(5);
    chk("ovf_valid_hold", 32'(dout_valid), 32'd1);
    dout_ack = 1'b1;
    wait_cyc(1);
    dout_ack = 1'b0;
    chk("ack_clears_valid", 32'(dout_valid), 32'd0);

    dout_ack = 1'b1;
    mon_en   = 1'b1;
    wait_cyc(TMO + 50);
    chk("timeout_set", 32'(sync_lost), 32'd1);
    run_frame(10, 20, 1'b0, -1, 1'b1);
    chk("timeout_clear", 32'(sync_lost), 32'd0);
    wait_cyc(TMO - 300);
    chk("timeout_early", 32'(sync_lost), 32'd0);
    wait_cyc(400);
    chk("timeout_again", 32'(sync_lost), 32'd1);
    run_frame(40, 90, 1'b0, -1, 1'b1);
    run_frame(0, 60, 1'b0, -1, 1'b1);
    chk("timeout_end", 32'(sync_lost), 32'd0);

    wait_cyc(20);
    chk("results_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
